// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: frame FSM state codes,
// the default bit period and the frame layout constants.
package uart_tx_port_pkg;

  // Default number of clk cycles per serial bit.
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Number of data bits carried by one 8N1 frame.
  localparam int FRAME_DATA_BITS = 8;

  // Frame FSM state codes.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Width of a counter that must hold the values 0..n-1 (n >= 2).
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_port_baud_tick.sv
// Bit-period counter for the UART transmit port. Counts 0..CLKS_PER_BIT-1,
// wraps on its terminal count and raises bit_end while sitting on it.
// clear holds the count at zero (used while the line is idle).
module uart_tx_port_baud_tick
  import uart_tx_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = count_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Free-running bit-period count, held at zero by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // The last cycle of every bit period.
  assign bit_end = (count == TERMINAL);

endmodule

// File: rtl/uart_tx_port.sv
// UART transmit port for the 8-bit CPU. Accepts a byte with a one-cycle load
// strobe while idle and shifts it out as an 8N1 frame, LSB first.
//
// Handshake: load is a request; it is accepted only in a cycle where busy is
// low (including the cycle where done pulses). An accepted load captures in,
// raises busy and drives the start bit from the next edge. Loads while busy
// are dropped without sampling in. done pulses for one cycle after the final
// stop-bit cycle, in the same cycle busy falls.
//
// All outputs are registered; tx never depends combinationally on inputs.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = FRAME_DATA_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  localparam int IDX_W = count_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_end;
  logic              cnt_clear;

  // The bit counter is held at zero while idle so that a START period always
  // begins from count 0. Every other state change happens on bit_end, where
  // the counter wraps to zero on its own.
  assign cnt_clear = (state == TX_IDLE);

  uart_tx_port_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .bit_end(bit_end)
  );

  // Frame FSM with registered tx/busy/done; owns the shift register and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tx      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (load) begin
            shift   <= in;
            bit_idx <= '0;
            busy    <= 1'b1;
            tx      <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx    <= shift[0];
            state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              // Next data bit is the one about to reach shift[0].
              tx      <= shift[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= TX_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
